// File: rtl/fir_decimator_fifo.sv
// Decimates the FIR output stream by a runtime ratio and buffers the kept samples
// in a first-word-fall-through FIFO read over a valid/ready handshake.
module fir_decimator_fifo #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned LVL_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_sample,
   input  logic [3:0]        ratio,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_sample,
   output logic [LVL_W-1:0]  fill_level,
   output logic              overflow
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [3:0]        r_phase;
   logic [3:0]        r_ratio;
   logic              r_fresh;
   logic [AW-1:0]     r_wr;
   logic [AW-1:0]     r_rd;
   logic [LVL_W-1:0]  r_lvl;
   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_sample;
   logic              r_ovf;

   logic [3:0]        w_ratio_eff;
   logic              w_wrap;
   logic              w_keep;
   logic              w_full;
   logic              w_pop;
   logic              w_push;
   logic              w_drop;
   logic [AW-1:0]     w_wr_nxt;
   logic [AW-1:0]     w_rd_nxt;
   logic [LVL_W-1:0]  w_lvl_nxt;
   logic [DATA_W-1:0] w_head_nxt;

   // The first period after reset release runs on the live ratio port value.
   always_comb begin
      w_ratio_eff = r_fresh ? ratio : r_ratio;
      w_wrap      = in_valid && (r_phase == w_ratio_eff);
      w_keep      = in_valid && (r_phase == 4'd0);
      w_full      = (r_lvl == LVL_W'(DEPTH));
      w_pop       = r_out_valid && out_ready;
      w_push      = w_keep && (!w_full || w_pop);
      w_drop      = w_keep && w_full && !w_pop;
      w_wr_nxt    = w_push ? (r_wr + AW'(1)) : r_wr;
      w_rd_nxt    = w_pop ? (r_rd + AW'(1)) : r_rd;
      w_lvl_nxt   = r_lvl;
      if (w_push && !w_pop) begin
         w_lvl_nxt = r_lvl + LVL_W'(1);
      end else if (w_pop && !w_push) begin
         w_lvl_nxt = r_lvl - LVL_W'(1);
      end
      // Head after this edge may be the sample being written right now.
      w_head_nxt = (w_push && (r_wr == w_rd_nxt)) ? in_sample : r_mem[w_rd_nxt];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_phase      <= 4'd0;
         r_ratio      <= 4'd0;
         r_fresh      <= 1'b1;
         r_wr         <= '0;
         r_rd         <= '0;
         r_lvl        <= '0;
         r_out_valid  <= 1'b0;
         r_out_sample <= '0;
         r_ovf        <= 1'b0;
      end else begin
         r_fresh <= 1'b0;
         if (in_valid) begin
            r_phase <= w_wrap ? 4'd0 : (r_phase + 4'd1);
         end
         if (r_fresh || w_wrap) begin
            r_ratio <= ratio;
         end
         r_wr         <= w_wr_nxt;
         r_rd         <= w_rd_nxt;
         r_lvl        <= w_lvl_nxt;
         r_out_valid  <= (w_lvl_nxt != '0);
         r_out_sample <= (w_lvl_nxt != '0) ? w_head_nxt : '0;
         if (w_drop) begin
            r_ovf <= 1'b1;
         end
      end
   end

   // Storage is not reset; validity is tracked by the level and pointers.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr] <= in_sample;
      end
   end

   assign out_valid  = r_out_valid;
   assign out_sample = r_out_sample;
   assign fill_level = r_lvl;
   assign overflow   = r_ovf;

endmodule
